dm_access_ctrl: RTL

DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

---
 rtl/dm_access_ctrl_pkg.sv | 17 +
 rtl/dm_access_ctrl_if.sv | 30 +++
 rtl/dm_access_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// Shared data-memory constants and controller state encoding, used by both the
// data memory and its access controller.
package dm_access_ctrl_pkg;

   localparam int unsigned DmDepth = 32;
   localparam int unsigned DmAddrW = 12;
   localparam int unsigned DmDataW = 32;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StWr    = 3'd1,
      StRd    = 3'd2,
      StRdCap = 3'd3,
      StRsp   = 3'd4
   } dm_state_e;

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Requester-side valid/ready request and response channels of the data-memory
// access controller.
interface dm_access_ctrl_if
   import dm_access_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = DmAddrW,
   parameter int unsigned DATA_W = DmDataW
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dm_access_ctrl.sv
// Single-outstanding access controller between a valid/ready requester and a
// synchronous data memory (read data registered by the memory one edge later).
module dm_access_ctrl
   import dm_access_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH  = DmDepth,
   parameter int unsigned ADDR_W = DmAddrW,
   parameter int unsigned DATA_W = DmDataW
) (
   input  logic              clk,
   input  logic              rst,
   dm_access_ctrl_if.slave   bus,
   output logic              dm_we_o,
   output logic [ADDR_W-1:0] dm_add_o,
   output logic [DATA_W-1:0] dm_data_o,
   input  logic [DATA_W-1:0] dm_out_i
);

   // One extra bit so DEPTH = 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DepthCmp = (ADDR_W + 1)'(DEPTH);

   dm_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              in_range;

   assign in_range = ({1'b0, bus.req_addr} < DepthCmp);

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      dm_we_o       = 1'b0;

      unique case (state_q)
         StIdle: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               rdata_d = '0;
               err_d   = ~in_range;
               if (!in_range) begin
                  state_d = StRsp;
               end else if (bus.req_we) begin
                  state_d = StWr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StWr: begin
            dm_we_o = 1'b1;
            state_d = StRsp;
         end
         StRd: begin
            state_d = StRdCap;
         end
         StRdCap: begin
            // Memory registered dm_out on the edge that ended StRd.
            rdata_d = dm_out_i;
            state_d = StRsp;
         end
         StRsp: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign dm_add_o      = addr_q;
   assign dm_data_o     = wdata_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule
